// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time through IDLE/ACCESS/WAIT/RESP, with load sign/zero extension.
// Optional LSU_MISALIGN_TRAP_EN faults misaligned half/word accesses instead of issuing them to memory.
module load_store_unit #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_is_store,
    input  logic [2:0]            i_funct3,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_rsp_valid,
    output logic [31:0]           o_rdata,
    output logic                  o_misaligned,
    output logic                  o_illegal,
    output logic [ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [ADDR_WIDTH-1:0] o_mem_raddr,
    output logic [31:0]           o_mem_din,
    output logic [1:0]            o_mem_size,
    output logic                  o_mem_wen,
    output logic                  o_mem_ren,
    input  logic [31:0]           i_mem_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    is_store_q;
    logic [2:0]              funct3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic                    accept;
    logic                    req_illegal;
    logic                    req_misaligned;
    logic [31:0]             load_ext;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^i_addr[31:ADDR_WIDTH];
    assign accept         = i_req_valid && o_req_ready;

    always_comb begin
        req_illegal = 1'b0;
        case (i_funct3)
            3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
            3'b100, 3'b101:         req_illegal = i_is_store;
            default:                req_illegal = 1'b1;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned_q;

    always_comb begin
        req_misaligned = 1'b0;
        if (!req_illegal) begin
            if (i_funct3[1:0] == 2'b01)
                req_misaligned = i_addr[0];
            else if (i_funct3[1:0] == 2'b10)
                req_misaligned = (i_addr[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst)
            misaligned_q <= 1'b0;
        else if (accept)
            misaligned_q <= req_misaligned;
    end

    assign o_misaligned = misaligned_q;
`else
    assign req_misaligned = 1'b0;
    assign o_misaligned   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (req_illegal || req_misaligned) ? RESP : ACCESS;
            ACCESS:  state_nxt = is_store_q ? RESP : WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are gated by reset so an aborted access never reaches memory.
    always_comb begin
        o_req_ready = (state == IDLE);
        o_rsp_valid = (state == RESP);
        o_mem_wen   = (state == ACCESS) && is_store_q && !i_rst;
        o_mem_ren   = (state == ACCESS) && !is_store_q && !i_rst;
    end

    assign o_mem_waddr = addr_q;
    assign o_mem_raddr = addr_q;
    assign o_mem_din   = wdata_q;

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   o_mem_size = 2'b01;
            2'b01:   o_mem_size = 2'b10;
            default: o_mem_size = 2'b11;
        endcase
    end

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{i_mem_dout[7]}}, i_mem_dout[7:0]};
            3'b100:  load_ext = {24'h0, i_mem_dout[7:0]};
            3'b001:  load_ext = {{16{i_mem_dout[15]}}, i_mem_dout[15:0]};
            3'b101:  load_ext = {16'h0, i_mem_dout[15:0]};
            default: load_ext = i_mem_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            o_rdata    <= '0;
            o_illegal  <= 1'b0;
        end else if (accept) begin
            is_store_q <= i_is_store;
            funct3_q   <= i_funct3;
            addr_q     <= i_addr[ADDR_WIDTH-1:0];
            wdata_q    <= i_wdata;
            o_rdata    <= '0;
            o_illegal  <= req_illegal;
        end else if (state == WAIT) begin
            o_rdata    <= load_ext;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expectations, a negedge monitor checks responses.
// Expectations for the misaligned load follow LSU_MISALIGN_TRAP_EN as defined for the build.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_is_store = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rdata;
    logic        o_misaligned;
    logic        o_illegal;
    logic [4:0]  o_mem_waddr;
    logic [4:0]  o_mem_raddr;
    logic [31:0] o_mem_din;
    logic [1:0]  o_mem_size;
    logic        o_mem_wen;
    logic        o_mem_ren;
    logic [31:0] i_mem_dout = '0;

    load_store_unit #(.ADDR_WIDTH(5)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_is_store(i_is_store), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rdata(o_rdata),
        .o_misaligned(o_misaligned), .o_illegal(o_illegal),
        .o_mem_waddr(o_mem_waddr), .o_mem_raddr(o_mem_raddr),
        .o_mem_din(o_mem_din), .o_mem_size(o_mem_size),
        .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren),
        .i_mem_dout(i_mem_dout)
    );

    always #5 clk = ~clk;

    // Byte-addressed little-endian memory; reads return four bytes starting at the address.
    logic [7:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (o_mem_wen) begin
            mem[o_mem_waddr] <= o_mem_din[7:0];
            if (o_mem_size != 2'b01) mem[o_mem_waddr + 5'd1] <= o_mem_din[15:8];
            if (o_mem_size == 2'b11) begin
                mem[o_mem_waddr + 5'd2] <= o_mem_din[23:16];
                mem[o_mem_waddr + 5'd3] <= o_mem_din[31:24];
            end
        end
        if (o_mem_ren)
            i_mem_dout <= {mem[o_mem_raddr + 5'd3], mem[o_mem_raddr + 5'd2],
                           mem[o_mem_raddr + 5'd1], mem[o_mem_raddr]};
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] rdata;
        bit          ill;
        bit          mis;
        int          acc;
        int          lat;
        int          ren;
        int          wen;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   ren_cnt = 0;
    int   wen_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(negedge clk) begin
        if (i_rst) begin
            ren_cnt = 0;
            wen_cnt = 0;
            check("strobes_in_reset", {30'd0, o_mem_wen, o_mem_ren}, 32'd0);
        end else begin
            ren_cnt += int'(o_mem_ren);
            wen_cnt += int'(o_mem_wen);
            if (o_rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {31'd0, o_rsp_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rdata", o_rdata, e.rdata);
                    check("illegal", {31'd0, o_illegal}, {31'd0, e.ill});
                    check("misaligned", {31'd0, o_misaligned}, {31'd0, e.mis});
                    check("latency", 32'(cycle - e.acc + 1), 32'(e.lat));
                    check("ren_pulses", 32'(ren_cnt), 32'(e.ren));
                    check("wen_pulses", 32'(wen_cnt), 32'(e.wen));
                end
                ren_cnt = 0;
                wen_cnt = 0;
            end
        end
    end

    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit push, input logic [31:0] erd,
                         input bit eill, input bit emis, input int elat, input int eren,
                         input int ewen);
        int waits;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_is_store  = st;
        i_funct3    = f3;
        i_addr      = a;
        i_wdata     = wd;
        waits = 0;
        while (!o_req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!o_req_ready) begin
            check("accept_timeout", {31'd0, o_req_ready}, 32'd1);
            i_req_valid = 1'b0;
            return;
        end
        if (push) sb.push_back('{erd, eill, emis, cycle + 1, elat, eren, ewen});
        @(posedge clk);
        #1 i_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, o_req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("reset_rdata", o_rdata, 32'd0);
        check("reset_illegal", {31'd0, o_illegal}, 32'd0);
        check("reset_misaligned", {31'd0, o_misaligned}, 32'd0);
        i_rst = 1'b0;

        //     st    f3      addr    wdata         push  rdata         ill   mis   lat ren wen
        issue(1'b1, 3'b010, 32'h04, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b0, 1'b0, 2, 0, 1);
        issue(1'b0, 3'b010, 32'h04, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 3, 1, 0);
        issue(1'b1, 3'b000, 32'h08, 32'h00000080, 1'b1, 32'h00000000, 1'b0, 1'b0, 2, 0, 1);
        issue(1'b0, 3'b000, 32'h08, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 3, 1, 0);
        issue(1'b0, 3'b100, 32'h08, 32'h0,        1'b1, 32'h00000080, 1'b0, 1'b0, 3, 1, 0);
        issue(1'b1, 3'b001, 32'h0C, 32'h00008001, 1'b1, 32'h00000000, 1'b0, 1'b0, 2, 0, 1);
        issue(1'b0, 3'b001, 32'h0C, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 1'b0, 3, 1, 0);
        issue(1'b0, 3'b101, 32'h0C, 32'h0,        1'b1, 32'h00008001, 1'b0, 1'b0, 3, 1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h02, 32'h0,        1'b1, 32'h00000000, 1'b0, 1'b1, 1, 0, 0);
`else
        issue(1'b0, 3'b010, 32'h02, 32'h0,        1'b1, 32'hBEEF0000, 1'b0, 1'b0, 3, 1, 0);
`endif
        issue(1'b0, 3'b011, 32'h04, 32'h0,        1'b1, 32'h00000000, 1'b1, 1'b0, 1, 0, 0);
        issue(1'b1, 3'b100, 32'h10, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0, 1, 0, 0);
        issue(1'b0, 3'b000, 32'h0D, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 3, 1, 0);

        // Load aborted by reset while waiting for memory data: no response may follow.
        issue(1'b0, 3'b010, 32'h04, 32'h0,        1'b0, 32'h0,          1'b0, 1'b0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        i_rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", {31'd0, o_req_ready}, 32'd1);
        check("no_rsp_after_abort", {31'd0, o_rsp_valid}, 32'd0);
        repeat (3) @(negedge clk);

        issue(1'b0, 3'b010, 32'h04, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 3, 1, 0);

        for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, the data-memory byte-address width.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_req_valid  input  1  pipeline presents a memory request.
REQ-005 SHALL have port o_req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port i_is_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port i_funct3  input  3  RV32I width/sign code.
REQ-008 SHALL have port i_addr  input  32  byte address; only bits [ADDR_WIDTH-1:0] are used.
REQ-009 SHALL have port i_wdata  input  32  store data, LSB-justified.
REQ-010 SHALL have port o_rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port o_rdata  output  32  extended load result.
REQ-012 SHALL have port o_misaligned  output  1  misalignment fault flag, qualified by o_rsp_valid.
REQ-013 SHALL have port o_illegal  output  1  unsupported funct3 flag, qualified by o_rsp_valid.
REQ-014 SHALL have ports o_mem_waddr and o_mem_raddr  output  ADDR_WIDTH  memory write/read byte addresses.
REQ-015 SHALL have ports o_mem_din (output 32), o_mem_size (output 2: 01 byte, 10 half, 11 word), o_mem_wen and o_mem_ren (output 1 each), and i_mem_dout (input 32, lane-0-justified read data, valid the cycle after o_mem_ren).

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-017 SHALL set o_req_ready=1 only in IDLE; a request is accepted on an edge with i_req_valid && o_req_ready, and the unit latches i_is_store, i_funct3, i_addr and i_wdata on that edge.
REQ-018 SHALL ignore i_req_valid in any other state; the requester holds the request until it is accepted.
REQ-019 SHALL decode loads as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU and stores as 000 SB, 001 SH, 010 SW; all other codes are illegal.
REQ-020 SHALL transition IDLE->ACCESS on accept of a legal, non-faulting request, and IDLE->RESP with o_illegal=1 (no memory access) on an illegal code.
REQ-021 SHALL, in ACCESS, drive o_mem_size from the latched code, both addresses with the latched address, and o_mem_din with the latched data; exactly one cycle of o_mem_wen (store) or o_mem_ren (load).
REQ-022 SHALL go ACCESS->RESP for a store and ACCESS->WAIT for a load.
REQ-023 SHALL, in WAIT, sample i_mem_dout, extend it (LB sign bit 7, LBU zero from bit 7, LH sign bit 15, LHU zero from bit 15, LW unchanged), register the result into o_rdata, and go to RESP.
REQ-024 SHALL assert o_rsp_valid for exactly the one RESP cycle, then return to IDLE; o_rdata is 0 for stores and faulted requests.
REQ-025 SHALL give latency from accept edge to o_rsp_valid of 2 cycles for stores, 3 cycles for loads, and 1 cycle for illegal or faulted requests.
REQ-026 SHALL hold o_mem_wen=o_mem_ren=0 outside ACCESS.

Reset
REQ-027 SHALL, on an edge with i_rst=1, enter IDLE and clear o_rsp_valid, o_rdata, o_misaligned, o_illegal and all latched request fields to 0, with o_req_ready=1 the following cycle.
REQ-028 SHALL, on reset mid-operation, abort the in-flight request: no response is produced, and memory strobes are forced to 0 while i_rst=1.

Configuration
REQ-029 SHALL recognise macro LSU_MISALIGN_TRAP_EN; when defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 does not touch memory and goes IDLE->RESP with o_misaligned=1.
REQ-030 SHALL, when LSU_MISALIGN_TRAP_EN is undefined, issue such accesses unchanged (the memory rotates lanes), and o_misaligned SHALL be constant 0.

Verification
REQ-031 SHALL cover: SW addr 0x04 data 0xDEADBEEF, then LW addr 0x04 -> o_rdata=0xDEADBEEF, rsp 3 cycles after load accept.
REQ-032 SHALL cover: SB addr 0x08 data 0x00000080, LB 0x08 -> 0xFFFFFF80; LBU 0x08 -> 0x00000080.
REQ-033 SHALL cover: SH addr 0x0C data 0x00008001, LH 0x0C -> 0xFFFF8001; LHU -> 0x00008001.
REQ-034 SHALL cover: LW addr 0x02 -> with macro o_misaligned=1, o_rdata=0, no o_mem_ren pulse; without macro a normal 3-cycle response.
REQ-035 SHALL cover: load funct3=011 -> o_illegal=1 one cycle after accept, no memory strobe.
REQ-036 SHALL cover: i_rst asserted in WAIT -> no o_rsp_valid, o_req_ready=1 the cycle after reset deasserts.
